// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART FIFO datapath.
package uart_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          r;
    v = (value > 1) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: one synchronous write port, one combinational read port, no reset.
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock UART data FIFO with occupancy count, threshold flag, sticky
// overflow/underflow errors and optional first-word-fall-through read.
module uart_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int FWFT  = FIFO_STD,
  parameter int CW    = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [CW-1:0]    level,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             half,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] head;
  logic             wr_req;
  logic             rd_req;
  logic             wr_acc;
  logic             rd_acc;

  always_comb begin
    full   = (cnt_q == CW'(DEPTH));
    empty  = (cnt_q == '0);
    half   = (cnt_q >= level);
    count  = cnt_q;
    wr_req = ~write_n;
    rd_req = ~read_n;
    rd_acc = rd_req & ~empty;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_acc = wr_req & (~full | rd_acc);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      // A new error in the same cycle as err_clr keeps the flag set.
      if (wr_req && !wr_acc) overflow <= 1'b1;
      else if (err_clr)      overflow <= 1'b0;
      if (rd_req && !rd_acc) underflow <= 1'b1;
      else if (err_clr)      underflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      assign data_out = head;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clock or posedge reset) begin
        if (reset)       dout_q <= '0;
        else if (rd_acc) dout_q <= head;
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: doc/uart_sync_fifo.md
# uart_sync_fifo

Parametrised single-clock FIFO for the CoreUARTapb transmit and receive data paths. It replaces the fixed 256x8 controller/RAM pair with generic width and depth, and its full flag covers the whole depth. It adds an occupancy count, a programmable threshold flag, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between the APB register interface and the UART TX/RX shift logic, clocked by the system clock.

## Interface
- WIDTH, 8: data width in bits.
- DEPTH, 256: number of entries; power of two, 4 to 1024.
- FWFT, 0: 0 = standard read (data registered 1 cycle after read); 1 = head word presented before read.
- CW, clog2(DEPTH+1): width of count/level; derived, not overridden.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  WIDTH  write data.
- write_n  in  1  write strobe, active low, one word per cycle.
- read_n  in  1  read strobe, active low, one word per cycle.
- level  in  CW  threshold for `half`.
- err_clr  in  1  synchronous clear of `overflow`/`underflow`, active high.
- data_out  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- half  out  1  count >= level.
- count  out  CW  current occupancy.
- overflow  out  1  sticky: write attempted while full without simultaneous read.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Reset values: count = 0, rd_ptr = wr_ptr = 0, data_out = 0, empty = 1, full = 0, overflow = underflow = 0. `half` = (level == 0).
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count is CW bits, so DEPTH is representable and full means DEPTH words stored.
- Write accepted when write_n = 0 and (not full, or a read is accepted in the same cycle). The accepted write stores data_in at wr_ptr and increments wr_ptr.
- Read accepted when read_n = 0 and not empty. An accepted read increments rd_ptr.
- Count update: write only → +1; read only → −1; both accepted → unchanged.
- Empty with both strobes: read rejected and underflow set; write accepted; count becomes 1.
- Full with both strobes: both accepted; count stays DEPTH; no overflow.
- Rejected write: memory and pointers unchanged; overflow set.
- Rejected read: pointers and data_out unchanged; underflow set.
- err_clr clears both sticky flags. If a new error occurs in the same cycle as err_clr, the error wins and the flag stays set.
- Standard mode (FWFT = 0): data_out is a register loaded with mem[rd_ptr] on an accepted read. It holds its value otherwise.
- FWFT mode (FWFT = 1): data_out = mem[rd_ptr] combinationally. It is valid whenever empty = 0 and is don't-care when empty. An accepted read advances to the next word.
- `half`, `full`, `empty` and `count` are combinational decodes of the count register. `level` may change at any time and takes effect combinationally.
- Reset asserted mid-operation discards all contents and returns every output to its reset value immediately (asynchronous). Memory contents are not cleared.

## Timing
- Write at edge N: count, empty, full and half reflect the write after edge N.
- FWFT: a word written into an empty FIFO at edge N is visible on data_out after edge N.
- Standard read: read_n low before edge N → word on data_out after edge N (1-cycle latency). This replaces the previous 2-cycle hold-based latency.
- Back-to-back reads or writes are sustained at one per clock with no bubbles.
- Flags update in the same edge as the count register; no extra latency.

## Structure
- Shared package `uart_fifo_pkg`:
  - clog2 function.
  - mode constants FIFO_STD = 0, FIFO_FWFT = 1.
- Sub-module `uart_fifo_mem`:
  - DEPTH×WIDTH register array, one synchronous write port, one combinational read port, no reset.
  - Keeps the array inferable as LSRAM/uSRAM by synthesis.
- The controller holds the pointers, count, error flags and output register.

## Test plan
- Reset, then 8 writes of 0x01..0x08 (WIDTH = 8, DEPTH = 16, FWFT = 0), then 8 reads → data_out 0x01..0x08, one cycle after each read; count 8→0; empty = 1 at end.
- Fill DEPTH = 16 → full = 1 and count = 16. 17th write → overflow = 1, count 16, contents intact. err_clr → overflow = 0.
- Empty FIFO, simultaneous read and write of 0xA5 → underflow = 1, count = 1. Full FIFO, simultaneous read and write → count 16, no overflow, FIFO order preserved.
- level = 5, write 4 → half = 0; 5th write → half = 1; one read → half = 0.
- FWFT = 1: write 0x3C into empty → data_out = 0x3C and empty = 0 the next cycle, before any read. Read → empty = 1.
- Pointer wrap: 3×DEPTH interleaved writes/reads with random data → scoreboard matches. Assert reset mid-stream → all outputs at reset values in the same cycle.
